// File: rtl/subcode_sequencer.sv
// rtl/subcode_sequencer.sv - CD-ROM subchannel sync hunt, SCCK burst deserialiser and symbol FIFO
module subcode_sequencer #(
    parameter int SCCK_DIV   = 2,
    parameter int FIFO_DEPTH = 16,
    parameter int FRAME_LEN  = 98
) (
    input  logic                          CDAC,
    input  logic                          IFRST,
    input  logic                          EFFK,
    input  logic                          SCOR,
    input  logic                          SBCP,
    input  logic                          ENABLE,
    input  logic                          RD,
    input  logic                          CLR_ERR,
    output logic                          SCCK,
    output logic [8:0]                    RDATA,
    output logic                          EMPTY,
    output logic [$clog2(FIFO_DEPTH):0]   COUNT,
    output logic                          FRAME_DONE,
    output logic [2:0]                    ERR
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FRAME_LEN);
    localparam logic [3:0]    DIV_LAST = 4'(SCCK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_LEN - 1);
    localparam logic [AW:0]   FIFO_FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HUNT,
        S_WAIT,
        S_SHIFT,
        S_PUSH
    } state_t;

    state_t         state_q;
    logic [2:0]     effk_sync_q;
    logic [2:0]     scor_sync_q;
    logic           effk_e_q;
    logic           scor_e_q;
    logic           scck_q;
    logic [3:0]     div_q;
    logic [2:0]     bit_q;
    logic [7:0]     shift_q;
    logic [CW-1:0]  cnt_q;
    logic           sync_pending_q;
    logic           frame_done_q;
    logic [2:0]     err_q;

    logic [8:0]     mem_q [FIFO_DEPTH];
    logic [AW:0]    wr_ptr_q;
    logic [AW:0]    rd_ptr_q;

    logic [AW:0]    count_w;
    logic           empty_w;
    logic           full_w;
    logic           push_req;
    logic           pop_ok;
    logic           push_ok;
    logic           in_frame;
    logic [2:0]     err_set_d;

    // Strobe synchronisers with registered rising-edge pulses
    always_ff @(posedge CDAC) begin
        if (IFRST) begin
            effk_sync_q <= 3'b000;
            scor_sync_q <= 3'b000;
            effk_e_q    <= 1'b0;
            scor_e_q    <= 1'b0;
        end else begin
            effk_sync_q <= {effk_sync_q[1:0], EFFK};
            scor_sync_q <= {scor_sync_q[1:0], SCOR};
            effk_e_q    <= effk_sync_q[1] & ~effk_sync_q[2];
            scor_e_q    <= scor_sync_q[1] & ~scor_sync_q[2];
        end
    end

    assign count_w  = wr_ptr_q - rd_ptr_q;
    assign empty_w  = (count_w == '0);
    assign full_w   = (count_w == FIFO_FULL_CNT);
    assign push_req = (state_q == S_PUSH) && ENABLE && !IFRST;
    assign pop_ok   = RD && !empty_w;
    // A full FIFO still accepts the symbol when the head is popped in the same cycle
    assign push_ok  = push_req && (!full_w || pop_ok);
    assign in_frame = (state_q == S_WAIT) || (state_q == S_SHIFT) || (state_q == S_PUSH);

    // Error events raised this cycle; only meaningful while capture is enabled
    always_comb begin
        err_set_d = 3'b000;
        if (ENABLE) begin
            if (scor_e_q && in_frame && (cnt_q != '0)) begin
                err_set_d[0] = 1'b1;
            end
            if (push_req && full_w && !pop_ok) begin
                err_set_d[1] = 1'b1;
            end
            if (effk_e_q && ((state_q == S_SHIFT) || (state_q == S_PUSH))) begin
                err_set_d[2] = 1'b1;
            end
        end
    end

    // Sequencer: sync hunt, SCCK burst generation, deserialisation and frame counting
    always_ff @(posedge CDAC) begin
        if (IFRST) begin
            state_q        <= S_IDLE;
            scck_q         <= 1'b0;
            div_q          <= '0;
            bit_q          <= '0;
            shift_q        <= '0;
            cnt_q          <= '0;
            sync_pending_q <= 1'b0;
            frame_done_q   <= 1'b0;
            err_q          <= '0;
        end else begin
            frame_done_q <= 1'b0;
            err_q        <= (CLR_ERR ? 3'b000 : err_q) | err_set_d;
            if (!ENABLE) begin
                state_q        <= S_IDLE;
                scck_q         <= 1'b0;
                div_q          <= '0;
                bit_q          <= '0;
                cnt_q          <= '0;
                sync_pending_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        state_q <= S_HUNT;
                    end
                    S_HUNT: begin
                        if (scor_e_q) begin
                            state_q        <= S_WAIT;
                            cnt_q          <= '0;
                            sync_pending_q <= 1'b1;
                        end
                    end
                    S_WAIT: begin
                        if (effk_e_q) begin
                            state_q <= S_SHIFT;
                            scck_q  <= 1'b1;
                            div_q   <= '0;
                            bit_q   <= '0;
                        end
                    end
                    S_SHIFT: begin
                        if (div_q == DIV_LAST) begin
                            div_q <= '0;
                            if (scck_q) begin
                                // Data is taken on the falling SCCK edge, MSB (P) first
                                scck_q  <= 1'b0;
                                shift_q <= {shift_q[6:0], SBCP};
                            end else if (bit_q == 3'd7) begin
                                state_q <= S_PUSH;
                            end else begin
                                scck_q <= 1'b1;
                                bit_q  <= bit_q + 3'd1;
                            end
                        end else begin
                            div_q <= div_q + 4'd1;
                        end
                    end
                    S_PUSH: begin
                        state_q        <= S_WAIT;
                        sync_pending_q <= 1'b0;
                        if (cnt_q == CNT_LAST) begin
                            cnt_q        <= '0;
                            frame_done_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
                // A resync restarts the frame; the in-flight symbol becomes symbol 0
                if (scor_e_q && in_frame) begin
                    cnt_q          <= '0;
                    sync_pending_q <= 1'b1;
                end
            end
        end
    end

    // FIFO pointers; occupancy is derived from their difference
    always_ff @(posedge CDAC) begin
        if (IFRST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
        end
    end

    // FIFO storage write of the tagged symbol
    always_ff @(posedge CDAC) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {sync_pending_q, shift_q};
        end
    end

    assign SCCK       = scck_q;
    assign FRAME_DONE = frame_done_q;
    assign ERR        = err_q;
    assign COUNT      = count_w;
    assign EMPTY      = empty_w;
    assign RDATA      = empty_w ? 9'h000 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: tb/tb_subcode_sequencer.sv
// tb/tb_subcode_sequencer.sv - directed self-checking bench for subcode_sequencer
module tb_subcode_sequencer;

    logic       CDAC = 1'b0;
    logic       IFRST, EFFK, SCOR, SBCP, ENABLE, RD, CLR_ERR;
    logic       SCCK;
    logic [8:0] RDATA;
    logic       EMPTY;
    logic [2:0] COUNT;
    logic       FRAME_DONE;
    logic [2:0] ERR;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          fd_cnt   = 0;
    logic [7:0]  tx_sym   = 8'h00;
    logic [2:0]  bit_idx  = 3'd0;
    logic        scck_prev = 1'b0;
    logic        scck_seen = 1'b0;
    logic [63:0] wave;
    logic [63:0] exp_wave;
    logic [7:0]  sym;

    always #5 CDAC = ~CDAC;

    subcode_sequencer #(
        .SCCK_DIV  (3),
        .FIFO_DEPTH(4),
        .FRAME_LEN (98)
    ) dut (
        .CDAC      (CDAC),
        .IFRST     (IFRST),
        .EFFK      (EFFK),
        .SCOR      (SCOR),
        .SBCP      (SBCP),
        .ENABLE    (ENABLE),
        .RD        (RD),
        .CLR_ERR   (CLR_ERR),
        .SCCK      (SCCK),
        .RDATA     (RDATA),
        .EMPTY     (EMPTY),
        .COUNT     (COUNT),
        .FRAME_DONE(FRAME_DONE),
        .ERR       (ERR)
    );

    // Drive model: present the next bit on each SCCK rise, MSB first
    always @(negedge CDAC) begin
        if (SCCK && !scck_prev) begin
            SBCP = tx_sym[3'd7 - bit_idx];
            bit_idx = bit_idx + 3'd1;
        end
        scck_prev = SCCK;
        if (SCCK) scck_seen = 1'b1;
        if (FRAME_DONE) fd_cnt = fd_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CDAC);
    endtask

    task automatic start_effk(input logic [7:0] s);
        tx_sym  = s;
        bit_idx = 3'd0;
        wave    = '0;
        EFFK    = 1'b1;
    endtask

    task automatic send_sym(input logic [7:0] s);
        start_effk(s);
        for (int k = 1; k <= 60; k++) begin
            tick(1);
            wave[k] = SCCK;
            if (k == 3) EFFK = 1'b0;
        end
    endtask

    task automatic pulse_scor();
        SCOR = 1'b1;
        tick(3);
        SCOR = 1'b0;
        tick(3);
    endtask

    task automatic clr_err();
        CLR_ERR = 1'b1;
        tick(1);
        CLR_ERR = 1'b0;
    endtask

    task automatic pop();
        RD = 1'b1;
        tick(1);
        RD = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [8:0] exp);
        check(tag, {55'd0, RDATA}, {55'd0, exp});
        pop();
    endtask

    initial begin
        IFRST = 1'b1; EFFK = 1'b0; SCOR = 1'b0; SBCP = 1'b0;
        ENABLE = 1'b0; RD = 1'b0; CLR_ERR = 1'b0;
        tick(3);
        check("rst_scck", SCCK, 0);
        check("rst_rdata", RDATA, 0);
        check("rst_empty", EMPTY, 1);
        check("rst_count", COUNT, 0);
        check("rst_frame_done", FRAME_DONE, 0);
        check("rst_err", ERR, 0);
        IFRST = 1'b0;

        // Basic frame: SCOR then 98 symbols, popping each one
        ENABLE = 1'b1;
        tick(2);
        pulse_scor();
        fd_cnt = 0;
        for (int i = 0; i < 98; i++) begin
            sym = (i == 0) ? 8'hA5 : 8'(i);
            send_sym(sym);
            if (i == 0) begin
                for (int k = 0; k < 64; k++)
                    exp_wave[k] = (k >= 4) && (k < 52) && (((k - 4) % 6) < 3);
                check("scck_wave", wave, exp_wave);
            end
            if (i == 96) check("frame_done_early", fd_cnt, 0);
            pop_check($sformatf("frame_sym%0d", i), {(i == 0), sym});
        end
        check("frame_done_once", fd_cnt, 1);
        check("frame_err", ERR, 0);
        check("frame_empty", EMPTY, 1);

        // Overrun: six symbols into a four-entry FIFO with no reads
        for (int i = 0; i < 6; i++) send_sym(8'h11 + 8'(i));
        check("ovr_count", COUNT, 4);
        check("ovr_err", ERR, 3'b010);
        for (int i = 0; i < 4; i++)
            pop_check($sformatf("ovr_sym%0d", i), {1'b0, 8'h11 + 8'(i)});
        check("ovr_drained", EMPTY, 1);
        clr_err();
        check("ovr_clr", ERR, 0);

        // Full FIFO with a pop in the push cycle loses nothing
        for (int i = 0; i < 4; i++) send_sym(8'h21 + 8'(i));
        start_effk(8'h25);
        tick(3);
        EFFK = 1'b0;
        tick(49);
        RD = 1'b1;
        tick(1);
        RD = 1'b0;
        tick(7);
        check("poppush_count", COUNT, 4);
        check("poppush_err", ERR, 0);
        for (int i = 0; i < 4; i++)
            pop_check($sformatf("poppush_sym%0d", i), {1'b0, 8'h22 + 8'(i)});

        // Sync error: SCOR after 40 symbols restarts the frame
        IFRST = 1'b1;
        tick(1);
        IFRST = 1'b0;
        tick(2);
        pulse_scor();
        for (int i = 0; i < 40; i++) begin
            send_sym(8'(i));
            pop();
        end
        check("sync_err_clear_before", ERR, 0);
        pulse_scor();
        check("sync_err", ERR, 3'b001);
        fd_cnt = 0;
        send_sym(8'h5A);
        pop_check("resync_flag", 9'h15A);
        for (int i = 1; i < 97; i++) begin
            send_sym(8'(i));
            pop();
        end
        check("resync_fd_early", fd_cnt, 0);
        send_sym(8'h61);
        pop();
        check("resync_fd", fd_cnt, 1);

        // Missed strobe: second EFFK mid-burst
        clr_err();
        start_effk(8'h77);
        tick(3);
        EFFK = 1'b0;
        tick(17);
        EFFK = 1'b1;
        tick(3);
        EFFK = 1'b0;
        tick(50);
        check("missed_err", ERR, 3'b100);
        check("missed_count", COUNT, 1);
        pop_check("missed_sym", 9'h077);
        clr_err();
        check("missed_clr", ERR, 0);

        // Abort after three SCCK pulses
        start_effk(8'h99);
        tick(3);
        EFFK = 1'b0;
        tick(18);
        ENABLE = 1'b0;
        tick(1);
        check("abort_scck", SCCK, 0);
        tick(40);
        check("abort_no_push", COUNT, 0);
        ENABLE = 1'b1;
        tick(2);
        scck_seen = 1'b0;
        send_sym(8'h42);
        check("hunt_no_push", COUNT, 0);
        check("hunt_no_scck", scck_seen, 0);
        pulse_scor();
        send_sym(8'h3C);
        check("reenable_sym", RDATA, 9'h13C);
        check("reenable_count", COUNT, 1);

        // Reset mid-burst with an error pending and a FIFO entry held
        start_effk(8'h10);
        tick(3);
        EFFK = 1'b0;
        tick(10);
        EFFK = 1'b1;
        tick(3);
        EFFK = 1'b0;
        tick(5);
        check("pre_rst_err", ERR, 3'b100);
        IFRST = 1'b1;
        tick(1);
        check("mid_rst_scck", SCCK, 0);
        check("mid_rst_empty", EMPTY, 1);
        check("mid_rst_count", COUNT, 0);
        check("mid_rst_rdata", RDATA, 0);
        check("mid_rst_err", ERR, 0);
        check("mid_rst_frame_done", FRAME_DONE, 0);
        IFRST = 1'b0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
